// File: rtl/mrmac_0_ctl_regs_axil.sv
// mrmac_0_ctl_regs_axil
// AXI4-Lite register bank owning the MRMAC example-design control plane:
// GT line rate / loopback, stretched GT reset pulses, per-port rate and
// segment configuration, trigger pulses, and synchronised reset-done status
// with sticky "done fell" flags.
// Optional feature: define MRMAC_CTL_STATUS_IRQ_EN to add the IRQEN register
// at 0x20 and the registered irq output.
module mrmac_0_ctl_regs_axil #(
    parameter logic [31:0] ID_VALUE         = 32'h4D52_0425,
    parameter int          RST_PULSE_CYCLES = 16,
    parameter int          SYNC_STAGES      = 2
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    // AXI4-Lite write address / data / response
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    // AXI4-Lite read address / data
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    // GT controls
    output logic [7:0]  gt_line_rate,
    output logic [2:0]  gt_loopback,
    output logic [3:0]  gt_reset_all_in,
    output logic [3:0]  gt_reset_tx_datapath_in,
    output logic [3:0]  gt_reset_rx_datapath_in,
    // Per-port controls
    output logic [2:0]  c0_top_ctl_data_rate,
    output logic [2:0]  c0_number_of_segments,
    output logic        c0_ten_gb_mode,
    output logic        c0_trig_in,
    output logic [2:0]  c1_top_ctl_data_rate,
    output logic [2:0]  c1_number_of_segments,
    output logic        c1_ten_gb_mode,
    output logic        c1_trig_in,
    output logic [2:0]  c2_top_ctl_data_rate,
    output logic [2:0]  c2_number_of_segments,
    output logic        c2_ten_gb_mode,
    output logic        c2_trig_in,
    output logic [2:0]  c3_top_ctl_data_rate,
    output logic [2:0]  c3_number_of_segments,
    output logic        c3_ten_gb_mode,
    output logic        c3_trig_in,
    // Miscellaneous
    output logic [2:0]  c0_top_ctl_muxes,
    output logic        c3_crc_fifo_reset,
`ifdef MRMAC_CTL_STATUS_IRQ_EN
    output logic        irq,
`endif
    input  logic [3:0]  stat_mst_reset_done
);

    localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_CYCLES);

    localparam logic [5:0] IDX_CTRL    = 6'd0;
    localparam logic [5:0] IDX_GTRST   = 6'd1;
    localparam logic [5:0] IDX_PORTCFG = 6'd2;
    localparam logic [5:0] IDX_MISC    = 6'd3;
    localparam logic [5:0] IDX_TRIG    = 6'd4;
    localparam logic [5:0] IDX_STATUS  = 6'd5;
    localparam logic [5:0] IDX_SCRATCH = 6'd6;
    localparam logic [5:0] IDX_ID      = 6'd7;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
    localparam logic [5:0] IDX_IRQEN   = 6'd8;
    localparam logic [5:0] LAST_IDX    = 6'd8;
`else
    localparam logic [5:0] LAST_IDX    = 6'd7;
`endif

    // Storage masks: bits outside these never hold a 1, so unused bits read 0
    localparam logic [31:0] CTRL_MASK    = 32'h0000_07FF;
    localparam logic [31:0] PORTCFG_MASK = 32'h7F7F_7F7F;
    localparam logic [31:0] MISC_MASK    = 32'h0000_0017;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
    localparam logic [31:0] IRQEN_MASK   = 32'h0000_000F;
`endif

    // Expand byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Byte-enabled merge of new write data into an existing register value
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (new_val & m);
    endfunction

    // Handshake and decode signals
    logic        ready_en;
    logic        wr_hs;
    logic        rd_hs;
    logic [5:0]  wr_idx;
    logic [5:0]  rd_idx;
    logic        wr_ok;
    logic        rd_ok;
    logic        wr_hit;
    logic [31:0] wmask;
    logic        unused_addr_bits;

    // Register state
    logic [31:0] ctrl_q;
    logic [31:0] portcfg_q;
    logic [31:0] misc_q;
    logic [31:0] scratch_q;
    logic [3:0]  trig_q;
    logic [3:0]  sticky_q;
    logic [7:0]  pulse_cnt [12];
    logic [11:0] pulse_vec;
    logic [11:0] pulse_set;
    logic [3:0]  sticky_clr;
    logic [3:0]  sync_q [SYNC_STAGES];
    logic [3:0]  synced;
    logic [3:0]  done_prev_q;
    logic [3:0]  done_fell;
    logic [31:0] rd_val;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
    logic [31:0] irqen_q;
    logic        irq_q;
`endif

    // The slave only accepts traffic once the clock has run with reset released,
    // so all ready outputs are low throughout reset.
    assign wr_hs         = ready_en & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = ready_en & ~s_axi_rvalid;
    assign rd_hs         = s_axi_arvalid & s_axi_arready;

    assign wr_idx = s_axi_awaddr[7:2];
    assign rd_idx = s_axi_araddr[7:2];
    assign wr_ok  = (s_axi_awaddr[31:8] == 24'd0) && (wr_idx <= LAST_IDX);
    assign rd_ok  = (s_axi_araddr[31:8] == 24'd0) && (rd_idx <= LAST_IDX);
    assign wr_hit = wr_hs & wr_ok;
    assign wmask  = strb_mask(s_axi_wstrb);

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write-1-pulse and write-1-clear strobes, byte-enabled
    assign pulse_set  = (wr_hit && wr_idx == IDX_GTRST)  ? (s_axi_wdata[11:0] & wmask[11:0]) : 12'd0;
    assign sticky_clr = (wr_hit && wr_idx == IDX_STATUS) ? (s_axi_wdata[7:4] & wmask[7:4])   : 4'd0;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign done_fell = done_prev_q & ~synced;

    // Track release of reset so the ready outputs stay low while in reset
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) ready_en <= 1'b0;
        else              ready_en <= 1'b1;
    end

    // Read/write control registers with byte enables
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            ctrl_q    <= '0;
            portcfg_q <= '0;
            misc_q    <= '0;
            scratch_q <= '0;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
            irqen_q   <= '0;
`endif
        end else if (wr_hit) begin
            case (wr_idx)
                IDX_CTRL:    ctrl_q    <= merge_bytes(ctrl_q, s_axi_wdata, s_axi_wstrb) & CTRL_MASK;
                IDX_PORTCFG: portcfg_q <= merge_bytes(portcfg_q, s_axi_wdata, s_axi_wstrb) & PORTCFG_MASK;
                IDX_MISC:    misc_q    <= merge_bytes(misc_q, s_axi_wdata, s_axi_wstrb) & MISC_MASK;
                IDX_SCRATCH: scratch_q <= merge_bytes(scratch_q, s_axi_wdata, s_axi_wstrb);
`ifdef MRMAC_CTL_STATUS_IRQ_EN
                IDX_IRQEN:   irqen_q   <= merge_bytes(irqen_q, s_axi_wdata, s_axi_wstrb) & IRQEN_MASK;
`endif
                default: ;
            endcase
        end
    end

    // GT reset stretchers: load on write-1 (reload extends an active pulse), count down to 0
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < 12; i++) pulse_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (pulse_set[i])             pulse_cnt[i] <= PULSE_LOAD;
                else if (pulse_cnt[i] != 8'd0) pulse_cnt[i] <= pulse_cnt[i] - 8'd1;
            end
        end
    end

    // Pulse outputs are high whenever their counter is non-zero
    always_comb begin
        pulse_vec = '0;
        for (int i = 0; i < 12; i++) pulse_vec[i] = (pulse_cnt[i] != 8'd0);
    end

    // Trigger pulses last exactly the cycle after the write handshake
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset)                        trig_q <= '0;
        else if (wr_hit && wr_idx == IDX_TRIG)   trig_q <= s_axi_wdata[3:0] & wmask[3:0];
        else                                     trig_q <= '0;
    end

    // Synchronise reset-done status into the register clock domain
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= stat_mst_reset_done;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Edge-detect flop and sticky "done fell" flags; a new fall beats a same-cycle clear
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            done_prev_q <= '0;
            sticky_q    <= '0;
        end else begin
            done_prev_q <= synced;
            sticky_q    <= (sticky_q & ~sticky_clr) | done_fell;
        end
    end

`ifdef MRMAC_CTL_STATUS_IRQ_EN
    // Interrupt is a registered OR of enabled sticky flags
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) irq_q <= 1'b0;
        else              irq_q <= |(sticky_q & irqen_q[3:0]);
    end
    assign irq = irq_q;
`endif

    // Read data multiplexer; sees register state before any same-cycle write
    always_comb begin
        rd_val = 32'd0;
        case (rd_idx)
            IDX_CTRL:    rd_val = ctrl_q;
            IDX_GTRST:   rd_val = {20'd0, pulse_vec};
            IDX_PORTCFG: rd_val = portcfg_q;
            IDX_MISC:    rd_val = misc_q;
            IDX_TRIG:    rd_val = 32'd0;
            IDX_STATUS:  rd_val = {24'd0, sticky_q, synced};
            IDX_SCRATCH: rd_val = scratch_q;
            IDX_ID:      rd_val = ID_VALUE;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
            IDX_IRQEN:   rd_val = irqen_q;
`endif
            default:     rd_val = 32'd0;
        endcase
    end

    // Write response channel: one outstanding write, held until bready
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else if (wr_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    // Read data channel: data captured at the handshake and held until rready
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'd0;
            s_axi_rresp  <= 2'b00;
        end else if (rd_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_ok ? rd_val : 32'd0;
            s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    assign gt_line_rate            = ctrl_q[7:0];
    assign gt_loopback             = ctrl_q[10:8];
    assign gt_reset_all_in         = pulse_vec[3:0];
    assign gt_reset_tx_datapath_in = pulse_vec[7:4];
    assign gt_reset_rx_datapath_in = pulse_vec[11:8];

    assign c0_top_ctl_data_rate  = portcfg_q[2:0];
    assign c0_number_of_segments = portcfg_q[5:3];
    assign c0_ten_gb_mode        = portcfg_q[6];
    assign c1_top_ctl_data_rate  = portcfg_q[10:8];
    assign c1_number_of_segments = portcfg_q[13:11];
    assign c1_ten_gb_mode        = portcfg_q[14];
    assign c2_top_ctl_data_rate  = portcfg_q[18:16];
    assign c2_number_of_segments = portcfg_q[21:19];
    assign c2_ten_gb_mode        = portcfg_q[22];
    assign c3_top_ctl_data_rate  = portcfg_q[26:24];
    assign c3_number_of_segments = portcfg_q[29:27];
    assign c3_ten_gb_mode        = portcfg_q[30];

    assign c0_trig_in = trig_q[0];
    assign c1_trig_in = trig_q[1];
    assign c2_trig_in = trig_q[2];
    assign c3_trig_in = trig_q[3];

    assign c0_top_ctl_muxes  = misc_q[2:0];
    assign c3_crc_fifo_reset = misc_q[4];

endmodule

// File: tb/tb_mrmac_0_ctl_regs_axil.sv
// Directed testbench for mrmac_0_ctl_regs_axil.
module tb_mrmac_0_ctl_regs_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [7:0]  gt_line_rate;
    logic [2:0]  gt_loopback;
    logic [3:0]  gt_reset_all_in, gt_reset_tx_datapath_in, gt_reset_rx_datapath_in;
    logic [2:0]  c0_rate, c1_rate, c2_rate, c3_rate;
    logic [2:0]  c0_seg, c1_seg, c2_seg, c3_seg;
    logic        c0_ten, c1_ten, c2_ten, c3_ten;
    logic        c0_trig, c1_trig, c2_trig, c3_trig;
    logic [2:0]  c0_muxes;
    logic        c3_crc;
`ifdef MRMAC_CTL_STATUS_IRQ_EN
    logic        irq;
`endif
    logic [3:0]  stat = 4'hF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mrmac_0_ctl_regs_axil dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .gt_line_rate(gt_line_rate), .gt_loopback(gt_loopback),
        .gt_reset_all_in(gt_reset_all_in), .gt_reset_tx_datapath_in(gt_reset_tx_datapath_in),
        .gt_reset_rx_datapath_in(gt_reset_rx_datapath_in),
        .c0_top_ctl_data_rate(c0_rate), .c0_number_of_segments(c0_seg), .c0_ten_gb_mode(c0_ten), .c0_trig_in(c0_trig),
        .c1_top_ctl_data_rate(c1_rate), .c1_number_of_segments(c1_seg), .c1_ten_gb_mode(c1_ten), .c1_trig_in(c1_trig),
        .c2_top_ctl_data_rate(c2_rate), .c2_number_of_segments(c2_seg), .c2_ten_gb_mode(c2_ten), .c2_trig_in(c2_trig),
        .c3_top_ctl_data_rate(c3_rate), .c3_number_of_segments(c3_seg), .c3_ten_gb_mode(c3_ten), .c3_trig_in(c3_trig),
        .c0_top_ctl_muxes(c0_muxes), .c3_crc_fifo_reset(c3_crc),
`ifdef MRMAC_CTL_STATUS_IRQ_EN
        .irq(irq),
`endif
        .stat_mst_reset_done(stat)
    );

    // Full write transaction; resp = 2'b11 if a handshake never happens
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'b11;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        n = 0;
        #1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL aw_timeout addr=%h awready=%b required 1", addr, s_axi_awready);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL b_timeout addr=%h bvalid=%b required 1", addr, s_axi_bvalid);
            return;
        end
        resp = s_axi_bresp;
        @(posedge clk);
    endtask

    // Full read transaction; resp = 2'b11 if a handshake never happens
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        resp = 2'b11; data = 32'hDEAD_BEEF;
        @(negedge clk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        n = 0;
        #1;
        while (!s_axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h arready=%b required 1", addr, s_axi_arready);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL r_timeout addr=%h rvalid=%b required 1", addr, s_axi_rvalid);
            return;
        end
        data = s_axi_rdata; resp = s_axi_rresp;
        @(posedge clk);
    endtask

    // Write address/data handshake only; returns at the negedge of the cycle after the handshake
    task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        n = 0;
        #1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL start_write_timeout addr=%h awready=%b required 1", addr, s_axi_awready);
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready aw=%b w=%b ar=%b required 0 0 0", s_axi_awready, s_axi_wready, s_axi_arready);
        end
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'd0 ||
            s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp bvalid=%b rvalid=%b rdata=%h required 0 0 0", s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
        end
        checks++;
        if ({gt_line_rate, gt_loopback, gt_reset_all_in, gt_reset_tx_datapath_in, gt_reset_rx_datapath_in,
             c0_rate, c3_seg, c1_ten, c0_trig, c0_muxes, c3_crc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs line_rate=%h loopback=%b required 0", gt_line_rate, gt_loopback);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        rst = 1'b0;
        axi_read(32'h1C, d, r);
        checks++;
        if (d !== 32'h4D52_0425 || r !== 2'b00) begin
            errors++; $display("FAIL id_read rdata=%h rresp=%b required 4d520425 00", d, r);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ctrl_after_reset rdata=%h required 0", d); end
    endtask

    task automatic test_ctrl();
        logic [31:0] d; logic [1:0] r;
        start_write(32'h00, 32'h0000_0519, 4'hF);
        checks++;
        if (gt_line_rate !== 8'h19 || gt_loopback !== 3'b101) begin
            errors++; $display("FAIL ctrl_outputs line_rate=%h loopback=%b required 19 101", gt_line_rate, gt_loopback);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h519 || r !== 2'b00) begin
            errors++; $display("FAIL ctrl_readback rdata=%h rresp=%b required 519 00", d, r);
        end
    endtask

    task automatic test_strobes_portcfg();
        logic [31:0] d; logic [1:0] r;
        axi_write(32'h18, 32'hAABB_CCDD, 4'hF, r);
        axi_write(32'h18, 32'h1122_3344, 4'b0101, r);
        axi_read(32'h18, d, r);
        checks++;
        if (d !== 32'hAA22_CC44) begin errors++; $display("FAIL scratch_wstrb rdata=%h required aa22cc44", d); end
        axi_write(32'h08, 32'hCAB5_FFA9, 4'hF, r);
        axi_read(32'h08, d, r);
        checks++;
        if (d !== 32'h4A35_7F29) begin errors++; $display("FAIL portcfg_readback rdata=%h required 4a357f29", d); end
        checks++;
        if ({c0_rate, c0_seg, c0_ten} !== 7'b001_101_0 || {c1_rate, c1_seg, c1_ten} !== 7'b111_111_1 ||
            {c2_rate, c2_seg, c2_ten} !== 7'b101_110_0 || {c3_rate, c3_seg, c3_ten} !== 7'b010_001_1) begin
            errors++;
            $display("FAIL portcfg_outputs c0=%b_%b_%b c3=%b_%b_%b required 001_101_0 010_001_1",
                     c0_rate, c0_seg, c0_ten, c3_rate, c3_seg, c3_ten);
        end
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(32'h0C, d, r);
        checks++;
        if (d !== 32'h17 || c0_muxes !== 3'b111 || c3_crc !== 1'b1) begin
            errors++; $display("FAIL misc rdata=%h muxes=%b crc=%b required 17 111 1", d, c0_muxes, c3_crc);
        end
    endtask

    task automatic test_gt_pulse();
        int cnt; int k;
        logic [31:0] d; logic [1:0] r;
        start_write(32'h04, 32'h0000_0F00, 4'hF);
        checks++;
        if (gt_reset_all_in !== 4'h0 || gt_reset_tx_datapath_in !== 4'h0) begin
            errors++; $display("FAIL gt_other_groups all=%h tx=%h required 0 0", gt_reset_all_in, gt_reset_tx_datapath_in);
        end
        cnt = 0;
        while (gt_reset_rx_datapath_in == 4'hF && cnt < 100) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt != 16) begin errors++; $display("FAIL gt_pulse_len cycles=%0d required 16", cnt); end
        // rewrite on the 10th active cycle extends the pulse
        start_write(32'h04, 32'h0000_0F00, 4'hF);
        cnt = 0; k = 1;
        while (gt_reset_rx_datapath_in == 4'hF && k < 100) begin
            cnt++;
            if (k == 10) begin
                s_axi_awaddr = 32'h04; s_axi_wdata = 32'h0F00; s_axi_wstrb = 4'hF;
                s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
            end
            if (k == 11) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
            k++;
            @(negedge clk);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++;
        if (cnt != 26) begin errors++; $display("FAIL gt_pulse_extended cycles=%0d required 26", cnt); end
        // byte strobe 1 only reaches GTRST[11:8]
        start_write(32'h04, 32'h0000_0FFF, 4'b0010);
        checks++;
        if (gt_reset_rx_datapath_in !== 4'hF || gt_reset_all_in !== 4'h0 || gt_reset_tx_datapath_in !== 4'h0) begin
            errors++;
            $display("FAIL gt_wstrb rx=%h all=%h tx=%h required f 0 0", gt_reset_rx_datapath_in, gt_reset_all_in, gt_reset_tx_datapath_in);
        end
        repeat (20) @(negedge clk);
        start_write(32'h04, 32'h0000_0000, 4'hF);
        checks++;
        if ({gt_reset_all_in, gt_reset_tx_datapath_in, gt_reset_rx_datapath_in} !== 12'h000) begin
            errors++; $display("FAIL gt_write0 pulses=%h required 000", {gt_reset_rx_datapath_in, gt_reset_tx_datapath_in, gt_reset_all_in});
        end
        start_write(32'h04, 32'h0000_000F, 4'hF);
        axi_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL gtrst_live_read rdata=%h required f", d); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_trig();
        logic [31:0] d; logic [1:0] r;
        start_write(32'h10, 32'h5, 4'hF);
        checks++;
        if ({c3_trig, c2_trig, c1_trig, c0_trig} !== 4'b0101) begin
            errors++; $display("FAIL trig_pulse trig=%b required 0101", {c3_trig, c2_trig, c1_trig, c0_trig});
        end
        @(negedge clk);
        checks++;
        if ({c3_trig, c2_trig, c1_trig, c0_trig} !== 4'b0000) begin
            errors++; $display("FAIL trig_one_cycle trig=%b required 0000", {c3_trig, c2_trig, c1_trig, c0_trig});
        end
        axi_read(32'h10, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL trig_read rdata=%h required 0", d); end
    endtask

    task automatic test_error();
        logic [31:0] d; logic [1:0] r;
        axi_read(32'h40, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL bad_read rdata=%h rresp=%b required 0 10", d, r); end
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL bad_write bresp=%b required 10", r); end
        axi_read(32'h18, d, r);
        checks++;
        if (d !== 32'hAA22_CC44) begin errors++; $display("FAIL bad_write_scratch rdata=%h required aa22cc44", d); end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h519 || gt_line_rate !== 8'h19) begin
            errors++; $display("FAIL bad_write_ctrl rdata=%h required 519", d);
        end
`ifndef MRMAC_CTL_STATUS_IRQ_EN
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL irqen_absent rdata=%h rresp=%b required 0 10", d, r); end
`endif
    endtask

    task automatic test_status();
        logic [31:0] d; logic [1:0] r;
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h0F) begin errors++; $display("FAIL status_idle rdata=%h required 0f", d); end
        @(negedge clk); stat = 4'hE;
        repeat (5) @(negedge clk);
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h1E) begin errors++; $display("FAIL status_fell rdata=%h required 1e", d); end
        axi_write(32'h14, 32'h10, 4'hF, r);
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h0E) begin errors++; $display("FAIL status_w1c rdata=%h required 0e", d); end
        @(negedge clk); stat = 4'hF;
        repeat (5) @(negedge clk);
        stat = 4'hE;
        @(negedge clk);
        @(negedge clk);
        // clear lands in the same cycle the synchronised fall re-sets sticky[0]
        s_axi_awaddr = 32'h14; s_axi_wdata = 32'h10; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        #1;
        checks++;
        if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL status_race_ready awready=%b required 1", s_axi_awready); end
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (3) @(negedge clk);
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h1E) begin errors++; $display("FAIL status_set_wins rdata=%h required 1e", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        s_axi_awaddr = 32'h00; s_axi_wdata = 32'h2A6; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        s_axi_araddr = 32'h00; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        #1;
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL same_cycle_ready aw=%b ar=%b required 1 1", s_axi_awready, s_axi_arready);
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h519 || s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_rw rvalid=%b rdata=%h bvalid=%b required 1 519 1", s_axi_rvalid, s_axi_rdata, s_axi_bvalid);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h2A6 || gt_line_rate !== 8'hA6 || gt_loopback !== 3'b010) begin
            errors++; $display("FAIL after_same_cycle rdata=%h line_rate=%h required 2a6 a6", d, gt_line_rate);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        s_axi_awaddr = 32'h04; s_axi_wdata = 32'hFFF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || gt_reset_all_in !== 4'hF) begin
            errors++; $display("FAIL pre_reset bvalid=%b all=%h required 1 f", s_axi_bvalid, gt_reset_all_in);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || {gt_reset_all_in, gt_reset_tx_datapath_in, gt_reset_rx_datapath_in} !== 12'h000 ||
            gt_line_rate !== 8'h00 || c1_ten !== 1'b0) begin
            errors++;
            $display("FAIL async_reset bvalid=%b pulses=%h line_rate=%h required 0 000 00", s_axi_bvalid,
                     {gt_reset_all_in, gt_reset_tx_datapath_in, gt_reset_rx_datapath_in}, gt_line_rate);
        end
        @(negedge clk);
        rst = 1'b0;
        s_axi_bready = 1'b1;
        axi_write(32'h00, 32'h123, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL post_reset_write bresp=%b required 00", r); end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h123) begin errors++; $display("FAIL post_reset_read rdata=%h required 123", d); end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_strobes_portcfg();
        test_gt_pulse();
        test_trig();
        test_error();
        test_status();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
